// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with a 2-entry in-order result buffer and a saturating a==b counter.
// Optional LOGIC_UNIT_SEG_EN adds a registered active-low seven-segment decode of the head result.
module logic_unit_pipe #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [6:0]       seg
);

  localparam logic [CNT_W-1:0] EqOne = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] EqMax = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    OpAnd  = 3'd0,
    OpOr   = 3'd1,
    OpXor  = 3'd2,
    OpXnor = 3'd3,
    OpNand = 3'd4,
    OpNor  = 3'd5,
    OpPass = 3'd6,
    OpNot  = 3'd7
  } op_e;

  function automatic logic [WIDTH-1:0] calc(input logic [WIDTH-1:0] x,
                                            input logic [WIDTH-1:0] y,
                                            input logic [2:0]       sel);
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (op_e'(sel))
      OpAnd:  r = x & y;
      OpOr:   r = x | y;
      OpXor:  r = x ^ y;
      OpXnor: r = ~(x ^ y);
      OpNand: r = ~(x & y);
      OpNor:  r = ~(x | y);
      OpPass: r = x;
      OpNot:  r = ~x;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] ent0_q, ent0_d;
  logic [WIDTH-1:0] ent1_q, ent1_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic [WIDTH-1:0] res;
  logic             push;
  logic             pop;

  // Handshake flags depend only on registered count.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign res       = calc(a, b, op);

  assign z      = out_valid ? ent0_q : '0;
  assign eq_cnt = eq_cnt_q;

  // ent0 is always the head; ent1 holds the second result when two are buffered.
  always_comb begin
    count_d = count_q;
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          ent0_d = res;
        end else begin
          ent1_d = res;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Only reachable at count 1: the old head leaves and the new result replaces it.
        ent0_d = res;
      end
      default: ;
    endcase
  end

  always_comb begin
    eq_cnt_d = eq_cnt_q;
    if (push && (a == b) && (eq_cnt_q != EqMax)) begin
      eq_cnt_d = eq_cnt_q + EqOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= 2'd0;
      ent0_q   <= '0;
      ent1_q   <= '0;
      eq_cnt_q <= '0;
    end else begin
      count_q  <= count_d;
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      eq_cnt_q <= eq_cnt_d;
    end
  end

`ifdef LOGIC_UNIT_SEG_EN
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    s = 7'h7F;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [6:0] seg_q, seg_d;

  // Decode from next-state head so the pattern tracks z with no extra cycle.
  always_comb begin
    seg_d = 7'h7F;
    if (count_d != 2'd0) begin
      seg_d = hex7(ent0_d[3:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= 7'h7F;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign seg = seg_q;
`else
  assign seg = 7'h7F;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=7, CNT_W=8).
module tb_logic_unit_pipe;

  logic       clk;
  logic       rst_n;
  logic [6:0] a;
  logic [6:0] b;
  logic [2:0] op;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] z;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] eq_cnt;
  logic [6:0] seg;

  int checks = 0;
  int errors = 0;

`ifdef LOGIC_UNIT_SEG_EN
  localparam logic [6:0] SegXor = 7'h46;
`else
  localparam logic [6:0] SegXor = 7'h7F;
`endif

  logic [6:0] va [10];
  logic [6:0] vb [10];
  logic [2:0] vo [10];
  logic [6:0] vz [10];

  logic_unit_pipe #(.WIDTH(7), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq_cnt    (eq_cnt),
    .seg       (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    va[0] = 7'h5A; vb[0] = 7'h33; vo[0] = 3'd0; vz[0] = 7'h12;
    va[1] = 7'h5A; vb[1] = 7'h33; vo[1] = 3'd1; vz[1] = 7'h7B;
    va[2] = 7'h5A; vb[2] = 7'h33; vo[2] = 3'd2; vz[2] = 7'h69;
    va[3] = 7'h5A; vb[3] = 7'h33; vo[3] = 3'd3; vz[3] = 7'h16;
    va[4] = 7'h5A; vb[4] = 7'h33; vo[4] = 3'd4; vz[4] = 7'h6D;
    va[5] = 7'h5A; vb[5] = 7'h33; vo[5] = 3'd5; vz[5] = 7'h04;
    va[6] = 7'h5A; vb[6] = 7'h33; vo[6] = 3'd6; vz[6] = 7'h5A;
    va[7] = 7'h5A; vb[7] = 7'h33; vo[7] = 3'd7; vz[7] = 7'h25;
    va[8] = 7'h7F; vb[8] = 7'h7F; vo[8] = 3'd2; vz[8] = 7'h00;
    va[9] = 7'h00; vb[9] = 7'h00; vo[9] = 3'd3; vz[9] = 7'h7F;

    rst_n = 1'b0; a = '0; b = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_z", z, 0);
    check("rst_eq_cnt", eq_cnt, 0);
    check("rst_seg", seg, 7'h7F);

    // XNOR of equal operands, first push right after reset release
    @(negedge clk);
    rst_n = 1'b1;
    a = 7'h55; b = 7'h55; op = 3'd3; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("xnor_z", z, 7'h7F);
    check("xnor_out_valid", out_valid, 1);
    check("xnor_eq_cnt", eq_cnt, 1);
    tick();
    check("xnor_popped_valid", out_valid, 0);
    check("xnor_popped_z", z, 0);

    // XOR with held output
    a = 7'h0F; b = 7'h33; op = 3'd2; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check("xor_z", z, 7'h3C);
    check("xor_eq_cnt", eq_cnt, 1);
    check("xor_seg", seg, SegXor);
    tick();
    check("xor_hold_z", z, 7'h3C);
    check("xor_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    tick();
    check("xor_pop_valid", out_valid, 0);
    check("xor_pop_seg", seg, 7'h7F);

    // Backpressure: two accepted, third held until space frees
    out_ready = 1'b0; in_valid = 1'b1; a = 7'h0F; b = 7'h33; op = 3'd0;
    tick();
    op = 3'd1;
    tick();
    check("bp_full_in_ready", in_ready, 0);
    op = 3'd2;
    tick();
    check("bp_held_in_ready", in_ready, 0);
    check("bp_head0", z, 7'h03);
    out_ready = 1'b1;
    tick();
    check("bp_head1", z, 7'h3F);
    check("bp_head1_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_head2", z, 7'h3C);
    check("bp_head2_valid", out_valid, 1);
    tick();
    check("bp_drained_valid", out_valid, 0);
    check("bp_drained_z", z, 0);
    check("bp_eq_cnt", eq_cnt, 1);

    // Continuous push/pop: count stays 1, one result per cycle in order
    for (int i = 0; i < 10; i++) begin
      a = va[i]; b = vb[i]; op = vo[i]; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      check($sformatf("stream_z%0d", i), z, vz[i]);
      check($sformatf("stream_rdy%0d", i), {out_valid, in_ready}, 2'b11);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end_valid", out_valid, 0);
    check("stream_eq_cnt", eq_cnt, 3);

    // Asynchronous reset with two entries buffered
    a = 7'h2A; b = 7'h2A; op = 3'd0; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_in_ready", in_ready, 0);
    check("pre_rst_eq_cnt", eq_cnt, 5);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_z", z, 0);
    check("mid_rst_eq_cnt", eq_cnt, 0);
    check("mid_rst_seg", seg, 7'h7F);
    out_ready = 1'b1;
    tick();
    check("in_rst_no_push", out_valid, 0);
    check("in_rst_eq_cnt", eq_cnt, 0);
    rst_n = 1'b1;

    // Saturation of eq_cnt
    a = 7'h11; b = 7'h11; op = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      tick();
      if (i == 254) check("sat_254", eq_cnt, 254);
      if (i == 255) check("sat_255", eq_cnt, 255);
    end
    check("sat_hold", eq_cnt, 255);
    check("sat_z", z, 7'h11);
    in_valid = 1'b0;
    tick();
    check("sat_final_valid", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 7, operand and result width (legal range 4..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of the equality counter.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port a, input, WIDTH bits: operand A.
REQ-006 SHALL have port b, input, WIDTH bits: operand B.
REQ-007 SHALL have port op, input, 3 bits: operation select.
REQ-008 SHALL have port in_valid, input, 1 bit: operands and op are valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-010 SHALL have port z, output, WIDTH bits: result at the buffer head.
REQ-011 SHALL have port out_valid, output, 1 bit: z is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer takes z.
REQ-013 SHALL have port eq_cnt, output, CNT_W bits: count of accepted operand pairs with a==b.
REQ-014 SHALL have port seg, output, 7 bits: active-low seven-segment pattern, bit order gfedcba.

Function
REQ-015 SHALL encode op as: 0 AND, 1 OR, 2 XOR, 3 XNOR, 4 NAND, 5 NOR, 6 pass A, 7 NOT A; all operations bitwise over WIDTH.
REQ-016 SHALL accept an operand pair on a rising edge where in_valid and in_ready are both 1, and compute the result from a, b and op sampled on that edge.
REQ-017 SHALL store results in a 2-entry in-order result buffer; count ranges 0..2.
REQ-018 SHALL drive in_ready = (count < 2) from registered state only, with no combinational path from out_ready.
REQ-019 SHALL drive out_valid = (count > 0), with z equal to the head entry.
REQ-020 SHALL pop the head on a rising edge where out_valid and out_ready are both 1.
REQ-021 SHALL give 1-cycle latency: a pair accepted at edge k into an empty buffer appears on z with out_valid=1 immediately after edge k.
REQ-022 SHALL handle simultaneous push and pop at count=1 as follows: count stays 1 and the new result becomes the head.
REQ-023 SHALL, at count=2, not accept a push (in_ready=0); a pop reduces count to 1.
REQ-024 SHALL hold z stable while out_valid=1 and out_ready=0.
REQ-025 SHALL drive z = 0 when count=0.
REQ-026 SHALL increment eq_cnt by 1 on each accepted pair with a==b, regardless of op, saturating at 2^CNT_W-1.
REQ-027 SHALL never lose or reorder results.

Reset
REQ-028 SHALL, while rst_n=0 (asynchronously, including mid-transaction), force: count=0, out_valid=0, in_ready=1, z=0, eq_cnt=0, seg=7'h7F.
REQ-029 SHALL discard all buffered results on reset, and accept no push or pop while rst_n=0.
REQ-030 SHALL allow the first push on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL use macro LOGIC_UNIT_SEG_EN. When defined: seg is a registered hex decode of the head entry's z[3:0], updated with the head; seg=7'h7F when count=0.
REQ-032 SHALL, when LOGIC_UNIT_SEG_EN is undefined: keep the seg port present, tie it to 7'h7F (all segments off), and compile in no decoder logic.

Verification
REQ-033 Reset: assert rst_n=0 mid-stream with 2 entries buffered -> out_valid=0, in_ready=1, z=0, eq_cnt=0 immediately, before any clock edge.
REQ-034 XNOR: a=7'h55, b=7'h55, op=3, out_ready=1 -> z=7'h7F with out_valid=1 one cycle later; eq_cnt=1.
REQ-035 XOR plus seg: a=7'h0F, b=7'h33, op=2 -> z=7'h3C, eq_cnt unchanged; seg=7'h46 with LOGIC_UNIT_SEG_EN defined, 7'h7F without.
REQ-036 Backpressure: out_ready=0, present ops 0, 1, 2 on a=7'h0F, b=7'h33 -> two accepted, in_ready=0, third held. Then out_ready=1 -> z sequence 7'h03, 7'h3F, 7'h3C.
REQ-037 Push/pop at count=1: continuous in_valid=1 and out_ready=1 for 10 pairs -> count stays 1, one result per cycle, in order.
REQ-038 Saturation: CNT_W=8, 260 accepted pairs with a==b -> eq_cnt=255 and holds.
